// File: rtl/msg_out_buffer.sv
// Output stage for extracted messages: FWFT FIFO with byte-length tagging,
// accept/drop statistics and sticky overflow / malformed-mask flags.
module msg_out_buffer #(
    parameter int DATA_WIDTH = 256,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int LEN_WIDTH  = $clog2(MASK_WIDTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [MASK_WIDTH-1:0]     in_bytemask,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [MASK_WIDTH-1:0]     out_bytemask,
    output logic [LEN_WIDTH-1:0]      out_len,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      mask_err,
    output logic [CNT_WIDTH-1:0]      msg_count,
    output logic [CNT_WIDTH-1:0]      drop_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [MASK_WIDTH-1:0] mem_mask [DEPTH];
    logic [LEN_WIDTH-1:0]  mem_len  [DEPTH];

    logic [PTR_W-1:0]     wp;
    logic [PTR_W-1:0]     rp;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;
    logic                 mask_legal;
    logic [LEN_WIDTH-1:0] in_len;

    assign empty   = (wp == rp);
    assign full    = (wp[IDX_W-1:0] == rp[IDX_W-1:0]) && (wp[IDX_W] != rp[IDX_W]);
    assign level   = wp - rp;
    assign pop     = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = in_valid && (!full || pop);
    assign drop    = in_valid && !push_ok;

    // Legal masks are 2^k-1: adding one clears every set bit.
    assign mask_legal = ((in_bytemask & (in_bytemask + MASK_WIDTH'(1))) == '0);

    always_comb begin
        in_len = '0;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            if (in_bytemask[i]) begin
                in_len = LEN_WIDTH'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp         <= '0;
            rp         <= '0;
            overflow   <= 1'b0;
            mask_err   <= 1'b0;
            msg_count  <= '0;
            drop_count <= '0;
        end else begin
            if (push_ok) begin
                wp        <= wp + PTR_W'(1);
                msg_count <= msg_count + CNT_WIDTH'(1);
            end
            if (pop) begin
                rp <= rp + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + CNT_WIDTH'(1);
                end
            end
            if (in_valid && !mask_legal) begin
                mask_err <= 1'b1;
            end
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (reset_n && push_ok) begin
            mem_data[wp[IDX_W-1:0]] <= in_data;
            mem_mask[wp[IDX_W-1:0]] <= in_bytemask;
            mem_len[wp[IDX_W-1:0]]  <= in_len;
        end
    end

    assign out_valid    = !empty;
    assign out_data     = mem_data[rp[IDX_W-1:0]];
    assign out_bytemask = mem_mask[rp[IDX_W-1:0]];
    assign out_len      = mem_len[rp[IDX_W-1:0]];

endmodule

// File: tb/tb_msg_out_buffer.sv
// Directed self-checking bench for msg_out_buffer (default parameters).
module tb_msg_out_buffer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [255:0] in_data;
    logic [31:0]  in_bytemask;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [31:0]  out_bytemask;
    logic [5:0]   out_len;
    logic [3:0]   level;
    logic         overflow;
    logic         mask_err;
    logic [15:0]  msg_count;
    logic [15:0]  drop_count;

    int checks = 0;
    int errors = 0;

    msg_out_buffer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_bytemask  (in_bytemask),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_bytemask (out_bytemask),
        .out_len      (out_len),
        .level        (level),
        .overflow     (overflow),
        .mask_err     (mask_err),
        .msg_count    (msg_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_data     = '0;
        in_bytemask = '0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++;
        if (out_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || mask_err !== 1'b0 ||
            msg_count !== 16'd0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b lvl=%0d ovf=%b merr=%b mc=%0d dc=%0d required all 0",
                     out_valid, level, overflow, mask_err, msg_count, drop_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_data     = 256'h0807060504030201;
        in_bytemask = 32'h0000_00FF;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_len !== 6'd8 || out_data !== 256'h0807060504030201 ||
            out_bytemask !== 32'h0000_00FF || msg_count !== 16'd1) begin
            errors++;
            $display("FAIL single_msg got v=%b len=%0d data=%h mask=%h mc=%0d required v=1 len=8 mask=ff mc=1",
                     out_valid, out_len, out_data[63:0], out_bytemask, msg_count);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            errors++;
            $display("FAIL single_drain got v=%b lvl=%0d required v=0 lvl=0", out_valid, level);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            in_valid    = 1'b1;
            in_data     = 256'(32'h100 + i);
            in_bytemask = 32'h0000_FFFF;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (level !== 4'd8 || overflow !== 1'b1 || drop_count !== 16'd2 || msg_count !== 16'd8 ||
            mask_err !== 1'b0) begin
            errors++;
            $display("FAIL fill_overflow got lvl=%0d ovf=%b dc=%0d mc=%0d merr=%b required 8 1 2 8 0",
                     level, overflow, drop_count, msg_count, mask_err);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 256'(32'h100 + i) || out_len !== 6'd16) begin
                errors++;
                $display("FAIL drain_order[%0d] got v=%b data=%h len=%0d required v=1 data=%h len=16",
                         i, out_valid, out_data[31:0], out_len, 32'h100 + i);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            errors++;
            $display("FAIL drain_empty got v=%b lvl=%0d required v=0 lvl=0", out_valid, level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid    = 1'b1;
            in_data     = 256'(32'h200 + i);
            in_bytemask = 32'h0000_000F;
            step();
        end
        in_data     = 256'h2FF;
        out_ready   = 1'b1;
        checks++;
        if (level !== 4'd8 || out_data !== 256'h200) begin
            errors++;
            $display("FAIL full_before got lvl=%0d head=%h required lvl=8 head=200", level, out_data[31:0]);
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (level !== 4'd8 || drop_count !== 16'd0 || msg_count !== 16'd9 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pop got lvl=%0d dc=%0d mc=%0d ovf=%b required 8 0 9 0",
                     level, drop_count, msg_count, overflow);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== ((i == 8) ? 256'h2FF : 256'(32'h200 + i))) begin
                errors++;
                $display("FAIL wrap_order[%0d] got v=%b data=%h", i, out_valid, out_data[31:0]);
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        in_valid    = 1'b1;
        in_bytemask = 32'h0000_0001;
        in_data     = 256'hAAAA;
        step();
        in_data     = 256'hBBBB;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 256'hAAAA || out_len !== 6'd1 || level !== 4'd2) begin
                errors++;
                $display("FAIL stall_hold[%0d] got v=%b data=%h len=%0d lvl=%0d required 1 aaaa 1 2",
                         i, out_valid, out_data[31:0], out_len, level);
            end
            step();
        end
        out_ready = 1'b1;
        checks++;
        if (out_data !== 256'hAAAA) begin
            errors++;
            $display("FAIL stall_pop0 got %h required aaaa", out_data[31:0]);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 256'hBBBB) begin
            errors++;
            $display("FAIL stall_pop1 got v=%b data=%h required 1 bbbb", out_valid, out_data[31:0]);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_empty got v=%b required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_mask();
        do_reset();
        in_valid    = 1'b1;
        in_data     = 256'h11;
        in_bytemask = 32'h0;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_len !== 6'd0 || out_bytemask !== 32'h0 || mask_err !== 1'b0 ||
            msg_count !== 16'd1) begin
            errors++;
            $display("FAIL mask_zero got v=%b len=%0d mask=%h merr=%b mc=%0d required 1 0 0 0 1",
                     out_valid, out_len, out_bytemask, mask_err, msg_count);
        end
        in_valid    = 1'b1;
        in_data     = 256'h22;
        in_bytemask = 32'h0000_00F5;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (mask_err !== 1'b1 || msg_count !== 16'd2) begin
            errors++;
            $display("FAIL mask_bad got merr=%b mc=%0d required 1 2", mask_err, msg_count);
        end
        step();
        out_ready = 1'b0;
        checks++;
        if (out_len !== 6'd8 || out_bytemask !== 32'h0000_00F5 || out_data !== 256'h22) begin
            errors++;
            $display("FAIL mask_len got len=%0d mask=%h data=%h required 8 f5 22",
                     out_len, out_bytemask, out_data[31:0]);
        end
        in_valid    = 1'b1;
        in_bytemask = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0;
        checks++;
        if (mask_err !== 1'b1 || level !== 4'd2) begin
            errors++;
            $display("FAIL mask_sticky got merr=%b lvl=%0d required 1 2", mask_err, level);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_bytemask = 32'hFFFF_FFFF;
        in_data     = 256'hC1;
        step();
        in_data = 256'hC2;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 256'hC2 || level !== 4'd1 || out_len !== 6'd32) begin
            errors++;
            $display("FAIL b2b_level1 got v=%b data=%h lvl=%0d len=%0d required 1 c2 1 32",
                     out_valid, out_data[31:0], level, out_len);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data     = 256'(32'h300 + i);
            in_bytemask = (i == 1) ? 32'h0000_0006 : 32'h0000_0003;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (level !== 4'd3 || mask_err !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got lvl=%0d merr=%b required 3 1", level, mask_err);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || level !== 4'd0 || msg_count !== 16'd0 || drop_count !== 16'd0 ||
            mask_err !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b lvl=%0d mc=%0d dc=%0d merr=%b ovf=%b required all 0",
                     out_valid, level, msg_count, drop_count, mask_err, overflow);
        end
        in_valid    = 1'b1;
        in_data     = 256'h3AA;
        in_bytemask = 32'h0000_0007;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 256'h3AA || level !== 4'd1 || out_len !== 6'd3) begin
            errors++;
            $display("FAIL post_reset_push got v=%b data=%h lvl=%0d len=%0d required 1 3aa 1 3",
                     out_valid, out_data[31:0], level, out_len);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_alone got v=%b required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_pop();
        test_stall();
        test_mask();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msg_out_buffer.md
Name: msg_out_buffer

Overview:
- Downstream stage of the message extractor. Captures each extracted message (256-bit data plus bytemask, single-cycle valid pulse, no backpressure).
- Buffers messages in a first-word-fall-through FIFO and presents them on a valid/ready interface to the consumer (host DMA or checker).
- Computes each message's byte length.
- Counts accepted and dropped messages and flags malformed bytemasks, because the producer cannot be stalled.

Parameters:
- DATA_WIDTH, 256, message data width in bits (multiple of 8).
- MASK_WIDTH, DATA_WIDTH/8, bytemask width; one bit per byte.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_WIDTH, 16, width of the statistics counters.
- LEN_WIDTH, $clog2(MASK_WIDTH)+1, width of out_len.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  message present this cycle (single-cycle pulse per message)
- in_data  in  DATA_WIDTH  message bytes; byte i is in_data[8i+:8]
- in_bytemask  in  MASK_WIDTH  valid-byte mask; contiguous from bit 0 when legal
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_data  out  DATA_WIDTH  head entry data
- out_bytemask  out  MASK_WIDTH  head entry mask
- out_len  out  LEN_WIDTH  head entry byte count
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; set when any message is dropped
- mask_err  out  1  sticky; set on a non-contiguous bytemask
- msg_count  out  CNT_WIDTH  accepted messages, wraps
- drop_count  out  CNT_WIDTH  dropped messages, saturates at all-ones

Behaviour:
- Reset: reset_n, synchronous, active-low; clock clk.
  - While reset_n=0 at a clk edge: pointers=0, level=0, out_valid=0, overflow=0, mask_err=0, msg_count=0, drop_count=0.
  - out_data, out_bytemask and out_len are don't-care while out_valid=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored entries immediately. The next cycle behaves as empty.
- Storage: DEPTH entries of {data, mask, len}. Write pointer wp and read pointer rp, each $clog2(DEPTH)+1 bits with a wrap bit.
  - empty when wp==rp.
  - full when the index bits are equal and the wrap bits differ.
  - level = wp-rp.
- pop = out_valid && out_ready.
- push_ok = in_valid && (!full || pop). When full, a simultaneous pop frees the slot, so the message is accepted in the same cycle.
- On push_ok:
  - Write entry at wp; wp++.
  - msg_count++ (mod 2^CNT_WIDTH).
- On in_valid && !push_ok:
  - Message dropped; overflow<=1.
  - drop_count++ unless it is already all-ones.
- Length: len = index of highest set bit of in_bytemask + 1. A zero mask gives len=0; the entry is still stored and counted.
- mask_err<=1 when in_valid and in_bytemask is not of the form 2^k-1 (k=0..MASK_WIDTH). It is set regardless of whether the message is dropped.
- Output:
  - out_valid = !empty.
  - out_data, out_bytemask and out_len come from the entry at rp.
  - Latency: a message pushed at edge N is visible with out_valid=1 after edge N (one cycle). There is no combinational in-to-out path.
- Consumer handshake:
  - Head entry and out_valid stay stable while out_valid && !out_ready.
  - On pop, rp++; the next entry appears the following cycle.
- Simultaneous push and pop while not full and not empty: level unchanged.
- Simultaneous push and pop with level=1: the new entry becomes head, and out_valid stays 1.
- Wrap: pointers wrap modulo 2*DEPTH. Ordering is strictly FIFO across wrap.
- overflow and mask_err clear only on reset.

Test Plan:
- Single message: in_bytemask=32'h0000_00FF, data 0x..0807060504030201, out_ready=1.
  - Expect out_valid one cycle later, out_len=8, exact data and mask.
  - Expect msg_count=1, then level returns to 0.
- Fill and overflow: out_ready=0, push 10 messages with DEPTH=8.
  - Expect level=8, overflow=1, drop_count=2, msg_count=8.
  - Then out_ready=1: the 8 oldest messages drain in order.
- Full with simultaneous pop: with level=8, assert out_ready=1 and in_valid=1 in the same cycle.
  - Expect the message accepted, level stays 8, drop_count unchanged.
- Stall stability: out_ready=0 for 5 cycles with 2 entries stored.
  - Expect the head entry to hold constant; assert on every cycle.
  - Then pops deliver both entries in order.
- Mask cases: push mask 32'h0 then 32'h0000_00F5.
  - Expect out_len=0, then out_len=8, and mask_err=1 after the second push only.
- Reset mid-operation: reset_n=0 for one cycle with 3 entries stored.
  - Expect out_valid=0, level=0 and all counters 0.
  - A following push appears alone.
